// File: rtl/emif_dpram_mailbox_if.sv
// emif_dpram_mailbox_if: EMIF strobes, user-port RAM access, doorbell and statistics signals of the mailbox.
interface emif_dpram_mailbox_if #(
    parameter int ADDR_W = 10
);
    logic              emif_dpram_wen;
    logic              emif_dpram_ren;
    logic [23:0]       emif_dpram_addr;
    logic [15:0]       emif_dpram_wdata;
    logic [15:0]       emif_rdata_o;
    logic              emif_rdata_vld_o;
    logic              usr_wr_en;
    logic [ADDR_W-1:0] usr_wr_addr;
    logic [15:0]       usr_wr_data;
    logic              usr_rd_en;
    logic [ADDR_W-1:0] usr_rd_addr;
    logic [15:0]       usr_rd_data;
    logic              usr_rd_vld;
    logic              usr_irq_ack;
    logic              irq_o;
    logic [7:0]        doorbell_cnt;
    logic              err_oor_o;
    logic [15:0]       stat_wr_cnt;
    logic [15:0]       stat_rd_cnt;

    modport master (
        output emif_dpram_wen, emif_dpram_ren, emif_dpram_addr, emif_dpram_wdata,
        output usr_wr_en, usr_wr_addr, usr_wr_data, usr_rd_en, usr_rd_addr, usr_irq_ack,
        input  emif_rdata_o, emif_rdata_vld_o, usr_rd_data, usr_rd_vld,
        input  irq_o, doorbell_cnt, err_oor_o, stat_wr_cnt, stat_rd_cnt
    );

    modport slave (
        input  emif_dpram_wen, emif_dpram_ren, emif_dpram_addr, emif_dpram_wdata,
        input  usr_wr_en, usr_wr_addr, usr_wr_data, usr_rd_en, usr_rd_addr, usr_irq_ack,
        output emif_rdata_o, emif_rdata_vld_o, usr_rd_data, usr_rd_vld,
        output irq_o, doorbell_cnt, err_oor_o, stat_wr_cnt, stat_rd_cnt
    );
endinterface

// File: rtl/emif_dpram_mailbox.sv
// emif_dpram_mailbox: 16-bit dual-port mailbox RAM between the EMIF (port A) and user logic (port B).
// Define EMIF_MBOX_STATS_EN to enable the saturating EMIF write/read-edge statistics counters.
module emif_dpram_mailbox #(
    parameter int              ADDR_W        = 10,
    parameter logic [23:0]     BASE_ADDR     = 24'h000000,
    parameter logic [ADDR_W-1:0] DOORBELL_ADDR = 10'h3FF,
    parameter logic [15:0]     OOR_RDATA     = 16'hDEAD
) (
    input logic                  clk_100m,
    input logic                  rst_n,
    emif_dpram_mailbox_if.slave  bus
);
    logic [15:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] off;
    logic              in_win, wr_ok, rd_edge, doorbell;
    logic              ren_q, rd_p_q, rd_oor_q, vld_q, err_q, irq_q, urd_vld_q;
    logic [15:0]       ram_a_q, rdata_q, urd_data_q;
    logic [7:0]        db_cnt_q;
    logic              err_d, irq_d;
    logic [7:0]        db_cnt_d;

    assign off      = bus.emif_dpram_addr[ADDR_W-1:0];
    assign in_win   = bus.emif_dpram_addr[23:ADDR_W] == BASE_ADDR[23:ADDR_W];
    assign wr_ok    = bus.emif_dpram_wen & in_win;
    assign rd_edge  = bus.emif_dpram_ren & ~ren_q;
    assign doorbell = wr_ok & (off == DOORBELL_ADDR);

    always_comb begin
        err_d    = (bus.emif_dpram_wen | rd_edge) & ~in_win;
        irq_d    = doorbell | (irq_q & ~bus.usr_irq_ack);
        db_cnt_d = db_cnt_q + 8'(doorbell);
    end

    // RAM array is not reset; on a same-offset write collision the EMIF write wins.
    always_ff @(posedge clk_100m) begin
        if (bus.usr_wr_en && !(wr_ok && bus.usr_wr_addr == off))
            mem[bus.usr_wr_addr] <= bus.usr_wr_data;
        if (wr_ok)
            mem[off] <= bus.emif_dpram_wdata;
        if (rd_edge)
            ram_a_q <= mem[off];
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            ren_q      <= 1'b0;
            rd_p_q     <= 1'b0;
            rd_oor_q   <= 1'b0;
            rdata_q    <= '0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
            db_cnt_q   <= '0;
            urd_data_q <= '0;
            urd_vld_q  <= 1'b0;
        end else begin
            ren_q     <= bus.emif_dpram_ren;
            rd_p_q    <= rd_edge;
            rd_oor_q  <= ~in_win;
            if (rd_p_q)
                rdata_q <= rd_oor_q ? OOR_RDATA : ram_a_q;
            vld_q     <= rd_p_q;
            err_q     <= err_d;
            irq_q     <= irq_d;
            db_cnt_q  <= db_cnt_d;
            if (bus.usr_rd_en)
                urd_data_q <= mem[bus.usr_rd_addr];
            urd_vld_q <= bus.usr_rd_en;
        end
    end

    assign bus.emif_rdata_o     = rdata_q;
    assign bus.emif_rdata_vld_o = vld_q;
    assign bus.usr_rd_data      = urd_data_q;
    assign bus.usr_rd_vld       = urd_vld_q;
    assign bus.irq_o            = irq_q;
    assign bus.doorbell_cnt     = db_cnt_q;
    assign bus.err_oor_o        = err_q;

`ifdef EMIF_MBOX_STATS_EN
    logic [15:0] swr_q, srd_q;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            swr_q <= '0;
            srd_q <= '0;
        end else begin
            swr_q <= swr_q + 16'(wr_ok && swr_q != 16'hFFFF);
            srd_q <= srd_q + 16'(rd_edge && in_win && srd_q != 16'hFFFF);
        end
    end

    assign bus.stat_wr_cnt = swr_q;
    assign bus.stat_rd_cnt = srd_q;
`else
    assign bus.stat_wr_cnt = '0;
    assign bus.stat_rd_cnt = '0;
`endif
endmodule

// File: tb/tb_emif_dpram_mailbox.sv
// tb_emif_dpram_mailbox: directed plus random stimulus against an array/counter model of the mailbox;
// read responses are queued with their due cycle and checked by an independent monitor.
module tb_emif_dpram_mailbox;
    localparam int AW = 10;
`ifdef EMIF_MBOX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [15:0] d;
        int          due;
    } exp_t;

    logic clk_100m = 1'b0;
    logic rst_n    = 1'b0;
    always #5 clk_100m = ~clk_100m;

    emif_dpram_mailbox_if #(.ADDR_W(AW)) bus ();
    emif_dpram_mailbox #(.ADDR_W(AW)) dut (.clk_100m(clk_100m), .rst_n(rst_n), .bus(bus));

    exp_t        q_emif[$];
    exp_t        q_usr[$];
    int          n_vec, n_err, cyc;
    logic [15:0] mem_m [1024];
    logic        prev_r, irq_e, err_e;
    logic [7:0]  cnt_e;
    int          wr_e, rd_e;

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Advance one clock, update the model from the inputs sampled at that edge, then check flags.
    task automatic step();
        logic       iw, edge_r, db;
        logic [9:0] off;
        @(posedge clk_100m);
        cyc++;
        if (!rst_n) begin
            q_emif.delete();
            q_usr.delete();
            prev_r = 0; irq_e = 0; err_e = 0; cnt_e = 0; wr_e = 0; rd_e = 0;
        end else begin
            iw     = bus.emif_dpram_addr[23:10] == 14'd0;
            off    = bus.emif_dpram_addr[9:0];
            edge_r = bus.emif_dpram_ren && !prev_r;
            prev_r = bus.emif_dpram_ren;
            if (edge_r) begin
                q_emif.push_back('{iw ? mem_m[off] : 16'hDEAD, cyc + 1});
                if (iw && rd_e < 65535) rd_e++;
            end
            if (bus.usr_rd_en) q_usr.push_back('{mem_m[bus.usr_rd_addr], cyc});
            err_e = (bus.emif_dpram_wen || edge_r) && !iw;
            db    = bus.emif_dpram_wen && iw && off == 10'h3FF;
            if (db) cnt_e++;
            irq_e = db || (irq_e && !bus.usr_irq_ack);
            if (bus.usr_wr_en) mem_m[bus.usr_wr_addr] = bus.usr_wr_data;
            if (bus.emif_dpram_wen && iw) begin
                mem_m[off] = bus.emif_dpram_wdata;
                if (wr_e < 65535) wr_e++;
            end
        end
        #1;
        chk("err_oor", bus.err_oor_o, err_e);
        chk("irq", bus.irq_o, irq_e);
        chk("doorbell_cnt", bus.doorbell_cnt, cnt_e);
        chk("stat_wr_cnt", bus.stat_wr_cnt, STATS ? wr_e : 0);
        chk("stat_rd_cnt", bus.stat_rd_cnt, STATS ? rd_e : 0);
    endtask

    task automatic emif_wr(logic [23:0] a, logic [15:0] d);
        bus.emif_dpram_wen = 1; bus.emif_dpram_addr = a; bus.emif_dpram_wdata = d;
        step();
        bus.emif_dpram_wen = 0;
    endtask

    task automatic emif_rd(logic [23:0] a);
        bus.emif_dpram_ren = 1; bus.emif_dpram_addr = a;
        step();
        bus.emif_dpram_ren = 0;
        step();
    endtask

    task automatic usr_rd(logic [9:0] a);
        bus.usr_rd_en = 1; bus.usr_rd_addr = a;
        step();
        bus.usr_rd_en = 0;
    endtask

    always @(negedge clk_100m) begin
        exp_t e;
        while (q_emif.size() != 0 && q_emif[0].due < cyc) begin
            e = q_emif.pop_front();
            chk("emif_vld_missing", cyc, e.due);
        end
        while (q_usr.size() != 0 && q_usr[0].due < cyc) begin
            e = q_usr.pop_front();
            chk("usr_vld_missing", cyc, e.due);
        end
        if (bus.emif_rdata_vld_o) begin
            chk("emif_vld_expected", int'(q_emif.size() != 0), 1);
            if (q_emif.size() != 0) begin
                e = q_emif.pop_front();
                chk("emif_rdata", bus.emif_rdata_o, e.d);
                chk("emif_latency", cyc, e.due);
            end
        end
        if (bus.usr_rd_vld) begin
            chk("usr_vld_expected", int'(q_usr.size() != 0), 1);
            if (q_usr.size() != 0) begin
                e = q_usr.pop_front();
                chk("usr_rd_data", bus.usr_rd_data, e.d);
                chk("usr_latency", cyc, e.due);
            end
        end
    end

    initial begin
        bus.emif_dpram_wen = 0; bus.emif_dpram_ren = 0; bus.emif_dpram_addr = '0; bus.emif_dpram_wdata = '0;
        bus.usr_wr_en = 0; bus.usr_wr_addr = '0; bus.usr_wr_data = '0;
        bus.usr_rd_en = 0; bus.usr_rd_addr = '0; bus.usr_irq_ack = 0;
        repeat (3) step();
        chk("rst_emif_rdata", bus.emif_rdata_o, 0);
        chk("rst_emif_vld", bus.emif_rdata_vld_o, 0);
        chk("rst_usr_rd_data", bus.usr_rd_data, 0);
        chk("rst_usr_vld", bus.usr_rd_vld, 0);
        rst_n = 1;
        bus.usr_wr_en = 1;
        for (int i = 0; i < 1024; i++) begin
            bus.usr_wr_addr = 10'(i); bus.usr_wr_data = 16'($urandom);
            step();
        end
        bus.usr_wr_en = 0;
        emif_wr(24'h000005, 16'h1234);
        emif_rd(24'h000005);
        repeat (3) step();
        chk("emif_rdata_hold", bus.emif_rdata_o, 16'h1234);
        bus.emif_dpram_ren = 1; bus.emif_dpram_addr = 24'h000005;
        repeat (10) step();
        bus.emif_dpram_ren = 0;
        step();
        emif_rd(24'h000005);
        repeat (3) step();
        repeat (3) emif_wr(24'h0003FF, 16'($urandom));
        step();
        chk("doorbell_cnt_3", bus.doorbell_cnt, 3);
        bus.usr_irq_ack = 1;
        step();
        bus.usr_irq_ack = 1;
        emif_wr(24'h0003FF, 16'h00AB);
        bus.usr_irq_ack = 0;
        step();
        bus.usr_irq_ack = 1;
        step();
        bus.usr_irq_ack = 0;
        emif_wr(24'h000400, 16'hBEEF);
        usr_rd(10'd0);
        emif_rd(24'h000400);
        repeat (3) step();
        bus.emif_dpram_wen = 1; bus.emif_dpram_addr = 24'h000007; bus.emif_dpram_wdata = 16'hAAAA;
        bus.usr_wr_en = 1; bus.usr_wr_addr = 10'd7; bus.usr_wr_data = 16'h5555;
        step();
        bus.emif_dpram_wen = 0; bus.usr_wr_en = 0;
        usr_rd(10'd7);
        step();
        chk("collision_usr_rd", bus.usr_rd_data, 16'hAAAA);
        bus.emif_dpram_ren = 1; bus.emif_dpram_addr = 24'h000005;
        step();
        rst_n = 0; bus.emif_dpram_ren = 0;
        repeat (2) step();
        rst_n = 1;
        repeat (4) step();
        chk("post_rst_emif_rdata", bus.emif_rdata_o, 0);
        for (int i = 0; i < 600; i++) begin
            bus.emif_dpram_wen   = ($urandom % 4) == 0;
            bus.emif_dpram_ren   = ($urandom % 3) == 0;
            bus.emif_dpram_wdata = 16'($urandom);
            case ($urandom % 8)
                0:       bus.emif_dpram_addr = 24'h0003FF;
                1:       bus.emif_dpram_addr = {14'($urandom_range(1, 16383)), 10'($urandom)};
                2:       bus.emif_dpram_addr = 24'h000007;
                default: bus.emif_dpram_addr = {14'd0, 10'($urandom)};
            endcase
            bus.usr_wr_en   = ($urandom % 3) == 0;
            bus.usr_wr_addr = ($urandom % 4 == 0) ? 10'd7 : 10'($urandom);
            bus.usr_wr_data = 16'($urandom);
            bus.usr_rd_en   = ($urandom % 2) == 0;
            bus.usr_rd_addr = ($urandom % 4 == 0) ? 10'd7 : 10'($urandom);
            bus.usr_irq_ack = ($urandom % 8) == 0;
            step();
        end
        bus.emif_dpram_wen = 0; bus.emif_dpram_ren = 0; bus.usr_wr_en = 0;
        bus.usr_rd_en = 0; bus.usr_irq_ack = 0;
        repeat (4) step();
        chk("emif_q_drained", q_emif.size(), 0);
        chk("usr_q_drained", q_usr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
